tc_serial_to_signmag: RTL and testbench

- Bit-serial converter from two's-complement to sign-magnitude.
- Inverse direction of the team's combinational two's-complement negator. It recovers sign and magnitude from a signed word using the LSB-first rule: copy bits up to and including the first 1, then invert the rest.
- Sits between signed datapath producers and magnitude-based consumers (display, PWM, sign-magnitude bus).
- Valid/ready handshakes on both sides; one conversion in flight at a time.

---
 rtl/tc_pkg.sv | 17 +
 rtl/tc_serial_cell.sv | 36 +++
 rtl/tc_serial_to_signmag.sv | 143 ++++++++++++++
 tb/tb_tc_serial_to_signmag.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the two's-complement serial converters.
// Provides the FSM state encoding and the default word width.
package tc_pkg;

    localparam int unsigned TC_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/tc_serial_cell.sv
// One-bit LSB-first negation cell: passes bits through until the first 1 has
// been seen, then inverts every following bit when neg is set.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   b          : current serial input bit
//   neg        : invert-after-first-one enable for this word
//   start      : clears the seen-one history at the start of a word
//   en         : advances the history by one bit
//   r          : converted output bit (combinational from b and history)
module tc_serial_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic b,
    input  logic neg,
    input  logic start,
    input  logic en,
    output logic r
);

    logic seen_one;

    // History of whether a 1 has already passed through this word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_one <= 1'b0;
        end else if (start) begin
            seen_one <= 1'b0;
        end else if (en) begin
            seen_one <= seen_one | b;
        end
    end

    // The first 1 itself is copied; only bits after it are inverted.
    assign r = (neg & seen_one) ? ~b : b;

endmodule

// File: rtl/tc_serial_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude converter.
// A word is accepted in IDLE, processed LSB-first over WIDTH cycles in SHIFT,
// and presented in DONE until the consumer takes it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data is the signed operand
//   out_valid/out_ready : output handshake
//   out_sign            : 1 for negative input
//   out_mag             : unsigned magnitude, exact for the most negative value
//   out_ovf             : magnitude needs all WIDTH bits
module tc_serial_to_signmag
    import tc_pkg::*;
#(
    parameter int unsigned WIDTH = TC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_ovf
);

    localparam int unsigned      CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH - 1){1'b0}}};

    state_t            state, state_d;
    logic [WIDTH-1:0]  sr, sr_d;
    logic [WIDTH-1:0]  res, res_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              neg, neg_d;
    logic              in_ready_d;
    logic              out_valid_d;
    logic              out_sign_d;
    logic [WIDTH-1:0]  out_mag_d;
    logic              out_ovf_d;
    logic              start_c;
    logic              en_c;
    logic              r_c;

    tc_serial_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .b     (sr[0]),
        .neg   (neg),
        .start (start_c),
        .en    (en_c),
        .r     (r_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d     = state;
        sr_d        = sr;
        res_d       = res;
        cnt_d       = cnt;
        neg_d       = neg;
        out_valid_d = out_valid;
        out_sign_d  = out_sign;
        out_mag_d   = out_mag;
        out_ovf_d   = out_ovf;
        start_c     = 1'b0;
        en_c        = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = in_data;
                    neg_d   = in_data[WIDTH-1];
                    cnt_d   = '0;
                    start_c = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                en_c  = 1'b1;
                // Result fills from the MSB end so the first bit lands in bit 0.
                res_d = {r_c, res[WIDTH-1:1]};
                sr_d  = {1'b0, sr[WIDTH-1:1]};
                cnt_d = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_sign_d  = neg;
                    out_mag_d   = res_d;
                    out_ovf_d   = neg & (res_d == MSB_ONLY);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // Datapath and output registers; in_ready comes out of reset high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            res       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_mag   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            sr        <= sr_d;
            res       <= res_d;
            cnt       <= cnt_d;
            neg       <= neg_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_sign  <= out_sign_d;
            out_mag   <= out_mag_d;
            out_ovf   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_tc_serial_to_signmag.sv
// Self-checking bench for tc_serial_to_signmag (WIDTH = 8).
module tb_tc_serial_to_signmag;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         sign;
        logic [W-1:0] mag;
        logic         ovf;
    } vec_t;

    typedef struct {
        vec_t v;
        int   hold;
    } tv_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         out_ovf;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t sb[$];

    tc_serial_to_signmag #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic absolute value, independent of the serial rule.
    function automatic vec_t model(input logic [W-1:0] d);
        vec_t v;
        v.data = d;
        v.sign = d[W-1];
        v.mag  = d[W-1] ? W'(-d) : d;
        v.ovf  = (d == 8'h80);
        return v;
    endfunction

    function automatic logic [31:0] pack_out(input logic v, input logic r, input logic s,
                                             input logic o, input logic [W-1:0] m);
        return 32'({v, r, s, o, m});
    endfunction

    // Wait (bounded) for out_valid; returns edges counted since the call.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Check the presented result against the scoreboard head, hold, then handshake.
    task automatic consume(input int hold, input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < hold; k++) begin
            chk({tag, "_hold"}, pack_out(out_valid, in_ready, out_sign, out_ovf, out_mag),
                pack_out(1'b1, 1'b0, e.sign, e.ovf, e.mag));
            @(posedge clk); #1;
        end
        chk({tag, "_result"}, pack_out(out_valid, in_ready, out_sign, out_ovf, out_mag),
            pack_out(1'b1, 1'b0, e.sign, e.ovf, e.mag));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        // Valid drops, input opens, result registers keep their value.
        chk({tag, "_after_hs"}, pack_out(out_valid, in_ready, out_sign, out_ovf, out_mag),
            pack_out(1'b0, 1'b1, e.sign, e.ovf, e.mag));
    endtask

    task automatic run_word(input vec_t v, input int hold, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        in_data  = v.data;
        sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(n);
        chk({tag, "_latency"}, 32'(n), 32'(W));
        consume(hold, tag);
    endtask

    tv_t tbl[10];

    initial begin
        int   n;
        logic seen;

        tbl[0] = '{'{8'h0A, 1'b0, 8'h0A, 1'b0}, 0};
        tbl[1] = '{'{8'hF6, 1'b1, 8'h0A, 1'b0}, 0};
        tbl[2] = '{'{8'h00, 1'b0, 8'h00, 1'b0}, 0};
        tbl[3] = '{'{8'h80, 1'b1, 8'h80, 1'b1}, 0};
        tbl[4] = '{'{8'hFF, 1'b1, 8'h01, 1'b0}, 0};
        tbl[5] = '{'{8'h5C, 1'b0, 8'h5C, 1'b0}, 5};
        tbl[6] = '{'{8'hC3, 1'b1, 8'h3D, 1'b0}, 1};
        tbl[7] = '{'{8'h7F, 1'b0, 8'h7F, 1'b0}, 0};
        tbl[8] = '{'{8'h01, 1'b0, 8'h01, 1'b0}, 2};
        tbl[9] = '{'{8'hA4, 1'b1, 8'h5C, 1'b0}, 0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", pack_out(out_valid, in_ready, out_sign, out_ovf, out_mag),
            pack_out(1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_word(tbl[i].v, tbl[i].hold, $sformatf("tbl%0d", i));
        end

        // in_valid held high across a busy period; second word waits for IDLE.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h81;
        sb.push_back('{8'h81, 1'b1, 8'h7F, 1'b0});
        @(posedge clk); #1;
        in_data = 8'h7F;
        wait_valid(n);
        chk("busy1_latency", 32'(n), 32'(W));
        chk("busy1_result", pack_out(out_valid, in_ready, out_sign, out_ovf, out_mag),
            pack_out(1'b1, 1'b0, sb[0].sign, sb[0].ovf, sb[0].mag));
        void'(sb.pop_front());
        @(posedge clk); #1;
        // Handshake edge coincided with in_valid: not taken in DONE.
        chk("busy_hs_idle", pack_out(out_valid, in_ready, 1'b0, 1'b0, 8'h00),
            pack_out(1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
        sb.push_back('{8'h7F, 1'b0, 8'h7F, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy2_accepted", 32'(in_ready), 32'd0);
        wait_valid(n);
        chk("busy2_latency", 32'(n), 32'(W));
        chk("busy2_result", pack_out(out_valid, in_ready, out_sign, out_ovf, out_mag),
            pack_out(1'b1, 1'b0, sb[0].sign, sb[0].ovf, sb[0].mag));
        void'(sb.pop_front());
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of SHIFT aborts the word.
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_reset_outputs", pack_out(out_valid, in_ready, out_sign, out_ovf, out_mag),
            pack_out(1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_idle_outputs", pack_out(out_valid, in_ready, out_sign, out_ovf, out_mag),
            pack_out(1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
        run_word('{8'hC3, 1'b1, 8'h3D, 1'b0}, 0, "post_reset");

        // Exhaustive sweep with random consumer stalls.
        for (int i = 0; i < 256; i++) begin
            run_word(model(W'(i)), int'($urandom_range(0, 3)), $sformatf("sweep%02h", i));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
